// File: rtl/urv_dbg_mbx_host.sv
// Debug-host side of the uRV debug mailbox: posts OWN-tagged requests into the core
// mailbox, waits for the firmware answer (OWN cleared) and returns it, with timeout/cancel.
module urv_dbg_mbx_host #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMER_W        = 11
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [30:0] req_data_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_timeout_o,
    output logic        busy_o,
    output logic [31:0] mbx_wdata_o,
    output logic        mbx_write_o,
    input  logic [31:0] mbx_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q;
    logic [30:0]          payload_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 retry_q;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic                 resp_timeout_q;
    logic [31:0]          resp_data_q;
    logic                 mbx_write_q;
    logic [31:0]          mbx_wdata_q;

    logic                 timer_done_s;
    logic [TIMER_W-1:0]   timer_inc_s;

    // Saturating timer increment: it parks at the timeout value instead of wrapping.
    always_comb begin
        timer_done_s = (timer_q == TIMER_LAST);
        if (timer_done_s) begin
            timer_inc_s = timer_q;
        end else begin
            timer_inc_s = timer_q + TIMER_W'(1);
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            payload_q      <= 31'd0;
            timer_q        <= '0;
            retry_q        <= 1'b0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_data_q    <= 32'd0;
            mbx_write_q    <= 1'b0;
            mbx_wdata_q    <= 32'd0;
        end else begin
            mbx_write_q <= 1'b0;
            mbx_wdata_q <= 32'd0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        payload_q   <= req_data_i;
                        req_ready_q <= 1'b0;
                        retry_q     <= 1'b0;
                        mbx_write_q <= 1'b1;
                        mbx_wdata_q <= {1'b1, req_data_i};
                        state_q     <= ST_WRITE;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // Only the first attempt starts the timeout window; retries keep counting.
                    timer_q <= retry_q ? timer_inc_s : '0;
                    state_q <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (mbx_rdata_i == {1'b1, payload_q}) begin
                        timer_q <= retry_q ? timer_inc_s : timer_q;
                        state_q <= ST_WAIT;
                    end else begin
                        // Core wrote on the same edge and won; re-post the request.
                        retry_q     <= 1'b1;
                        timer_q     <= timer_inc_s;
                        mbx_write_q <= 1'b1;
                        mbx_wdata_q <= {1'b1, payload_q};
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WAIT: begin
                    if (!mbx_rdata_i[31]) begin
                        resp_data_q    <= mbx_rdata_i;
                        resp_valid_q   <= 1'b1;
                        resp_timeout_q <= 1'b0;
                        state_q        <= ST_RESP;
                    end else if (timer_done_s) begin
                        resp_data_q    <= mbx_rdata_i;
                        resp_valid_q   <= 1'b1;
                        resp_timeout_q <= 1'b1;
                        mbx_write_q    <= 1'b1;
                        mbx_wdata_q    <= 32'd0;
                        state_q        <= ST_RESP;
                    end else begin
                        timer_q <= timer_inc_s;
                    end
                end
                ST_RESP: begin
                    if (resp_valid_q && resp_ready_i) begin
                        resp_valid_q   <= 1'b0;
                        resp_timeout_q <= 1'b0;
                        req_ready_q    <= 1'b1;
                        state_q        <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    req_ready_q    <= 1'b0;
                    resp_valid_q   <= 1'b0;
                    resp_timeout_q <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_timeout_o = resp_timeout_q;
    assign resp_data_o    = resp_data_q;
    assign mbx_write_o    = mbx_write_q;
    assign mbx_wdata_o    = mbx_wdata_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_urv_dbg_mbx_host.sv
// Randomized bench for urv_dbg_mbx_host: a cycle-counted core mailbox model plus a
// transaction-level reference for response words, latencies and mailbox write traffic.
module tb_urv_dbg_mbx_host;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [30:0] req_data_i = 31'd0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_data_o;
    logic        resp_timeout_o;
    logic        busy_o;
    logic [31:0] mbx_wdata_o;
    logic        mbx_write_o;
    logic [31:0] mbx_rdata_i;

    logic        core_we = 1'b0;
    logic [31:0] core_wd = 32'd0;
    logic [31:0] mbx_q = 32'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs  = 0;
    logic [31:0] wlog_d[$];
    int          wlog_c[$];

    urv_dbg_mbx_host #(.TIMEOUT_CYCLES(TMO), .TIMER_W(4)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_data_i     (req_data_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_data_o    (resp_data_o),
        .resp_timeout_o (resp_timeout_o),
        .busy_o         (busy_o),
        .mbx_wdata_o    (mbx_wdata_o),
        .mbx_write_o    (mbx_write_o),
        .mbx_rdata_i    (mbx_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Core mailbox register: a firmware write on the same edge beats the host write.
    always @(posedge clk_i) begin
        if (core_we) mbx_q <= core_wd;
        else if (mbx_write_o) mbx_q <= mbx_wdata_o;
    end
    assign mbx_rdata_i = mbx_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Write-traffic monitor: logs every pulse and checks wdata is zero otherwise.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (mbx_write_o) begin
                wlog_d.push_back(mbx_wdata_o);
                wlog_c.push_back(cyc);
            end else begin
                chk("wdata_idle", mbx_wdata_o, 32'd0);
            end
        end
    end

    // mode: 0 normal ack, 1 collision then ack, 2 silent core (timeout)
    task automatic run_txn(input logic [30:0] p, input logic [31:0] ack_w, input int mode,
                           input int dly, input int bp, input bit tied);
        int acc, lw, resp_c, guard, n0, hs;
        logic [31:0] exp_d;
        logic        exp_to;
        logic [31:0] ew[$];
        int          ec[$];
        resp_ready_i = tied;
        req_valid_i  = 1'b0;
        guard = 0;
        while (!req_ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        chk("req_ready", {31'd0, req_ready_o}, 32'd1);
        acc = cyc;
        chk("accept_cycle", acc, last_hs + 1);
        n0 = wlog_d.size();
        req_valid_i = 1'b1;
        req_data_i  = p;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_data_i  = 31'($urandom);
        chk("busy", {31'd0, busy_o}, 32'd1);
        chk("req_ready_low", {31'd0, req_ready_o}, 32'd0);
        lw = acc + 1;
        if (mode == 1) begin
            core_we = 1'b1;
            core_wd = 32'h0000_00AA;
            @(negedge clk_i);
            core_we = 1'b0;
            lw = acc + 3;
        end
        if (mode == 2) begin
            exp_d = {1'b1, p};
            exp_to = 1'b1;
            resp_c = acc + 3 + TMO;
        end else begin
            exp_d = ack_w;
            exp_to = 1'b0;
            resp_c = lw + dly + 2;
        end
        guard = 0;
        while (!resp_valid_o && guard < 80) begin
            core_we = (mode != 2) && (cyc == lw + dly);
            core_wd = ack_w;
            @(negedge clk_i);
            guard++;
        end
        core_we = 1'b0;
        chk("resp_valid", {31'd0, resp_valid_o}, 32'd1);
        chk("resp_cycle", cyc, resp_c);
        chk("resp_data", resp_data_o, exp_d);
        chk("resp_timeout", {31'd0, resp_timeout_o}, {31'd0, exp_to});
        if (tied) begin
            hs = cyc;
        end else begin
            for (int k = 0; k < bp; k++) begin
                req_valid_i = 1'($urandom_range(0, 1));
                req_data_i  = 31'($urandom);
                @(negedge clk_i);
                chk("hold_valid", {31'd0, resp_valid_o}, 32'd1);
                chk("hold_data", resp_data_o, exp_d);
                chk("hold_timeout", {31'd0, resp_timeout_o}, {31'd0, exp_to});
                chk("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
            end
            req_valid_i  = 1'b0;
            resp_ready_i = 1'b1;
            hs = cyc;
        end
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        chk("resp_clear", {31'd0, resp_valid_o}, 32'd0);
        chk("timeout_clear", {31'd0, resp_timeout_o}, 32'd0);
        chk("ready_after_hs", {31'd0, req_ready_o}, 32'd1);
        ew.push_back({1'b1, p});
        ec.push_back(acc + 1);
        if (mode == 1) begin
            ew.push_back({1'b1, p});
            ec.push_back(acc + 3);
        end
        if (mode == 2) begin
            ew.push_back(32'd0);
            ec.push_back(acc + 3 + TMO);
        end
        chk("n_writes", wlog_d.size() - n0, ew.size());
        for (int i = 0; i < ew.size(); i++) begin
            if (n0 + i < wlog_d.size()) begin
                chk("write_data", wlog_d[n0 + i], ew[i]);
                chk("write_cycle", wlog_c[n0 + i], ec[i]);
            end
        end
        last_hs = hs;
    endtask

    initial begin
        int n0;
        int m, d;
        repeat (2) @(negedge clk_i);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_write", {31'd0, mbx_write_o}, 32'd0);
        chk("rst_resp_data", resp_data_o, 32'd0);
        rst_n_i = 1'b1;
        chk("rel_req_ready_0", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk_i);
        chk("rel_req_ready_1", {31'd0, req_ready_o}, 32'd1);
        last_hs = cyc - 1;

        run_txn(31'h0000_1234, 32'h0000_5678, 0, 5, 0, 1'b0);
        run_txn(31'h0000_1234, 32'h0, 2, 0, 0, 1'b0);
        run_txn(31'h0000_1234, 32'h0000_0055, 1, 2, 0, 1'b0);
        run_txn(31'h0ABC_DEF0, 32'h0000_0777, 0, 3, 10, 1'b0);
        run_txn(31'h0000_0001, 32'h0000_0011, 0, 1, 0, 1'b1);
        run_txn(31'h0000_0002, 32'h0000_0022, 0, 1, 0, 1'b1);
        run_txn(31'h7FFF_FFFF, 32'h7FFF_FFFF, 0, TMO, 0, 1'b0);
        run_txn(31'h5555_5555, 32'h0, 2, 0, 4, 1'b1);

        for (int t = 0; t < 30; t++) begin
            m = $urandom_range(0, 3);
            if (m == 3) m = 0;
            d = (m == 1) ? $urandom_range(1, 8) : $urandom_range(1, TMO);
            run_txn(31'($urandom), {1'b0, 31'($urandom)}, m, d,
                    $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for the core
        while (!req_ready_o) @(negedge clk_i);
        req_valid_i = 1'b1;
        req_data_i  = 31'h0000_4321;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (6) @(negedge clk_i);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        n0 = wlog_d.size();
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_write", {31'd0, mbx_write_o}, 32'd0);
        chk("arst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("arst_req_ready", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        chk("rel2_req_ready_0", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk_i);
        chk("rel2_req_ready_1", {31'd0, req_ready_o}, 32'd1);
        chk("rel2_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("no_cancel_write", wlog_d.size() - n0, 32'd0);
        last_hs = cyc - 1;
        run_txn(31'h0000_0BEE, 32'h0000_0F00, 0, 2, 3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
